result_out_streamer: RTL and testbench



---
 rtl/tpu_out_pkg.sv | 21 ++
 rtl/result_row_buffer.sv | 35 +++
 rtl/result_out_streamer.sv | 101 ++++++++++
 tb/tb_result_out_streamer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_out_pkg.sv
// Shared geometry, FSM state type and lane-offset helper for the TPU output path.
// The lane layout places lane 0 at the MSBs of a row.
package tpu_out_pkg;

  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int DATA_W = 37;
  localparam int LINE_W = COLS * DATA_W;
  localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  function automatic int lane_lsb(input int j);
    return LINE_W - DATA_W * (j + 1);
  endfunction

endpackage

// File: rtl/result_row_buffer.sv
// Row storage for one result tile: one write port, one registered read port,
// with write-to-read forwarding when both ports address the same row.
module result_row_buffer
  import tpu_out_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] mem_q [ROWS];
  logic [LINE_W-1:0] rd_data_d;
  logic [LINE_W-1:0] rd_data_q;

  // Forwarding lets a tile whose last write lands on row 0 stream on the next cycle.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/result_out_streamer.sv
// Collects a full tile of result rows, then streams rows 0..ROWS-1 on gbuff_out,
// one per cycle with no gaps. Writes arriving while streaming are dropped and flagged.
module result_out_streamer
  import tpu_out_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              clear,
  output logic              out_valid,
  output logic [LINE_W-1:0] gbuff_out,
  output logic              busy,
  output logic              wr_drop
);

  state_e            state_q, state_d;
  logic [ROWS-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [LINE_W-1:0] rd_data;
  logic [ROWS-1:0]   wr_onehot;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    rd_addr   = '0;
    wr_onehot = '0;
    wr_onehot[wr_addr] = 1'b1;

    case (state_q)
      IDLE, FILL: begin
        if (clear) begin
          mask_d  = '0;
          state_d = IDLE;
        end else if (wr_en) begin
          mem_we  = 1'b1;
          mask_d  = mask_q | wr_onehot;
          state_d = (&mask_d) ? STREAM : FILL;
        end
      end
      STREAM: begin
        wr_drop_d = wr_en;
        // Read one row ahead so the registered read port lines up with cnt_q.
        rd_addr   = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(ROWS - 1)) begin
          state_d = IDLE;
          mask_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  result_row_buffer u_buf (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign out_valid = (state_q == STREAM);
  assign busy      = out_valid;
  assign wr_drop   = wr_drop_q;

  // Stale buffer contents never leak onto the pins outside a burst.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi);
    assign gbuff_out[LSB +: DATA_W] = out_valid ? rd_data[LSB +: DATA_W] : '0;
  end

endmodule

// File: tb/tb_result_out_streamer.sv
// Randomized scoreboard bench: a tile-level model queues expected rows, a monitor
// checks every cycle's outputs against that queue.
module tb_result_out_streamer;
  import tpu_out_pkg::*;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    int    row;
    line_t data;
  } exp_row_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  line_t             wr_data;
  logic              clear;
  logic              out_valid;
  line_t             gbuff_out;
  logic              busy;
  logic              wr_drop;

  result_out_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear     (clear),
    .out_valid (out_valid),
    .gbuff_out (gbuff_out),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Tile-level reference model
  line_t           model_mem [ROWS];
  logic [ROWS-1:0] model_mask = '0;
  int              stream_left = 0;
  logic            drop_exp = 1'b0;
  exp_row_t        exp_q [$];

  always @(posedge clk) begin
    if (rst) begin
      model_mask  = '0;
      stream_left = 0;
      drop_exp    = 1'b0;
      exp_q.delete();
    end else if (stream_left > 0) begin
      drop_exp = wr_en;
      stream_left--;
    end else begin
      drop_exp = 1'b0;
      if (clear) begin
        model_mask = '0;
      end else if (wr_en) begin
        model_mem[wr_addr]  = wr_data;
        model_mask[wr_addr] = 1'b1;
        if (model_mask == '1) begin
          for (int r = 0; r < ROWS; r++) exp_q.push_back('{row: r, data: model_mem[r]});
          model_mask  = '0;
          stream_left = ROWS;
        end
      end
    end
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit exp_v = (exp_q.size() > 0);
      chk_bit("out_valid", out_valid, exp_v);
      chk_bit("busy", busy, exp_v);
      chk_bit("wr_drop", wr_drop, drop_exp);
      if (exp_v) begin
        automatic exp_row_t e = exp_q.pop_front();
        if (out_valid) begin
          checks++;
          if (gbuff_out !== e.data) begin
            errors++;
            for (int j = 0; j < COLS; j++) begin
              if (gbuff_out[lane_lsb(j) +: DATA_W] !== e.data[lane_lsb(j) +: DATA_W]) begin
                $display("FAIL row_data row %0d lane %0d: got %h expected %h", e.row, j,
                         gbuff_out[lane_lsb(j) +: DATA_W], e.data[lane_lsb(j) +: DATA_W]);
                break;
              end
            end
          end else begin
            $display("out row %0d lane0=%h", e.row, gbuff_out[lane_lsb(0) +: DATA_W]);
          end
        end
      end else begin
        checks++;
        if (gbuff_out !== '0) begin
          errors++;
          $display("FAIL gbuff_zero at %0t: got %h expected 0", $time, gbuff_out[lane_lsb(0) +: DATA_W]);
        end
      end
    end
  end

  function automatic line_t rand_line();
    line_t d;
    for (int j = 0; j < COLS; j++) d[lane_lsb(j) +: DATA_W] = DATA_W'({$urandom, $urandom});
    return d;
  endfunction

  function automatic line_t fill_lanes(input logic [DATA_W-1:0] v);
    line_t d;
    for (int j = 0; j < COLS; j++) d[lane_lsb(j) +: DATA_W] = v;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int a, input line_t d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_done();
    int i = 0;
    while ((stream_left > 0 || exp_q.size() > 0) && i < 200) begin
      step();
      i++;
    end
    checks++;
    if (stream_left > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL stream_timeout: %0d rows still expected, required 0", exp_q.size());
    end
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0;
    step(); step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;

    // Ascending fill with lane pattern i*32+j
    for (int i = 0; i < ROWS; i++) begin
      line_t d;
      for (int j = 0; j < COLS; j++) d[lane_lsb(j) +: DATA_W] = DATA_W'(i * COLS + j);
      wr(i, d);
    end
    wait_done();

    // Descending fill, row 0 last exercises forwarding
    for (int i = ROWS - 1; i >= 0; i--) wr(i, rand_line());
    wait_done();

    // Repeat write to row 5; row 17 missing until later
    wr(5, fill_lanes(DATA_W'(1)));
    for (int i = 0; i < ROWS; i++) if (i != 5 && i != 17) wr(i, rand_line());
    wr(5, fill_lanes('1));
    idle(5);
    wr(17, rand_line());
    wait_done();

    // Partial fill, clear (also with a simultaneous write), then full fill
    for (int i = 0; i < 20; i++) wr(i, rand_line());
    clear = 1'b1;
    wr(25, rand_line());
    clear = 1'b0;
    for (int i = ROWS - 1; i >= 0; i--) wr(i, rand_line());
    wait_done();

    // Writes during STREAM, including the final STREAM cycle, are dropped
    for (int i = 0; i < ROWS; i++) wr(i, rand_line());
    idle(9);
    wr(7, rand_line());
    idle(21);
    wr(3, rand_line());
    for (int i = 0; i < ROWS; i++) wr((i * 7) % ROWS, rand_line());
    wait_done();

    // Reset in the middle of a burst
    for (int i = 0; i < ROWS; i++) wr(i, rand_line());
    idle(14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(3);
    for (int i = 0; i < ROWS; i++) wr(ROWS - 1 - i, rand_line());
    wait_done();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      int r = $urandom_range(0, 99);
      clear   = (r < 2);
      wr_en   = (r < 70);
      wr_addr = ADDR_W'($urandom_range(0, ROWS - 1));
      wr_data = rand_line();
      step();
    end
    clear = 1'b0;
    wr_en = 1'b0;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
